// File: rtl/sort_stream_7_if.sv
// Stream bundle for sort_stream_7: the unsorted input word stream and the
// ascending output word stream, each with a valid/ready handshake.
interface sort_stream_7_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  // Environment side: produces input words and consumes sorted words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Sorter side: consumes input words and produces sorted words.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_stream_7.sv
// sort_stream_7: collects a block of seven unsigned 32-bit words by insertion
// sort (one word per handshake), then streams the block out in ascending
// order and publishes the block median (sorted element 3).
module sort_stream_7 (
  input  logic           clk,
  input  logic           rst_n,
  sort_stream_7_if.slave bus,
  output logic [31:0]    median_o,
  output logic           median_valid_o
);
  localparam int N = 7;
  localparam int W = 32;
  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  state_t       state_q;
  logic [W-1:0] arr_q [N];
  logic [W-1:0] arr_d [N];
  logic [2:0]   cnt_q;
  logic [2:0]   rd_idx_q;
  logic [2:0]   pos;
  logic [N-1:0] le;
  logic [W-1:0] median_q;
  logic         median_valid_q;
  logic         accept;

  // Handshake qualifiers depend only on the registered state.
  assign accept = (state_q == FILL) && bus.in_valid;

  // Flag every filled entry that is <= the incoming word; equal words count,
  // so a new word lands after earlier equal words and ties stay stable.
  always_comb begin
    le = '0;
    for (int i = 0; i < N; i++) begin
      le[i] = (3'(i) < cnt_q) && (arr_q[i] <= bus.in_data);
    end
  end

  // The filled region is sorted, so the flag count is the insertion slot.
  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos = pos + {2'b00, le[i]};
    end
  end

  // Build the post-insertion array: below pos keep, at pos the new word,
  // above pos shift up by one (slots past cnt are don't-care).
  always_comb begin
    arr_d = arr_q;
    arr_d[0] = (pos == 3'd0) ? bus.in_data : arr_q[0];
    for (int i = 1; i < N; i++) begin
      if (3'(i) == pos) begin
        arr_d[i] = bus.in_data;
      end else if (3'(i) > pos) begin
        arr_d[i] = arr_q[i-1];
      end
    end
  end

  // Control FSM plus storage, fill count, read index and median registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      cnt_q          <= '0;
      rd_idx_q       <= '0;
      median_q       <= '0;
      median_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      median_valid_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < N; i++) begin
              arr_q[i] <= arr_d[i];
            end
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == LAST_IDX) begin
              state_q        <= DRAIN;
              rd_idx_q       <= '0;
              median_q       <= arr_d[3];
              median_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              state_q  <= FILL;
              cnt_q    <= '0;
              rd_idx_q <= '0;
            end else begin
              rd_idx_q <= rd_idx_q + 3'd1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == FILL);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_data   = (state_q == DRAIN) ? arr_q[rd_idx_q] : '0;
  assign bus.out_last   = (state_q == DRAIN) && (rd_idx_q == LAST_IDX);
  assign median_o       = median_q;
  assign median_valid_o = median_valid_q;

endmodule
